reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 155 +++++++++++++++
 tb/tb_reg_file_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file: N_RD registered read ports, one write port,
// r0 hardwired to zero, and a bulk-clear sweep that zeroes one entry per cycle.
//
// Ports:
//   clk      : clock; all state changes on the rising edge
//   clr_n    : asynchronous active-low reset
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  : packed registered read data, port k at [k*DATA_W +: DATA_W]
//   clr_req  : single-cycle request to start a clear sweep
//   busy     : high while the sweep runs
//   clr_done : one-cycle pulse after the final sweep entry is cleared
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a write forwards its data to any read port that samples
//   the same address on the same edge. When undefined, that read returns
//   the pre-write contents.

module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic              done_q;
  logic              done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q  [N_RD];
  logic [DATA_W-1:0] rd_d  [N_RD];

  logic sweep_clr;
  logic wr_ok;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        // Wraps to zero after the last entry, leaving IDLE with index 0.
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == SWEEP);
    clr_done  = done_q;
    sweep_clr = (state_q == SWEEP);
    // A clr_req cycle drops any write; r0 is never stored.
    wr_ok     = we && (state_q == IDLE) && !clr_req
                && (wr_addr != '0);
  end

  // Storage
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (sweep_clr) begin
      mem_q[idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read ports
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_d[k] = '0;
      if (!sweep_clr && (ra != '0)) begin
        rd_d[k] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == ra)) begin
          rd_d[k] = wr_data;
        end
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_q[k];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int k = 0; k < N_RD; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (DATA_W=32, ADDR_W=5, N_RD=2).
// Directed steps plus randomized traffic against a behavioural model.

module tb_reg_file_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clr_n = 1'b0;
  logic           we = 1'b0;
  logic           clr_req = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [AW-1:0]  ra [NR];
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic           busy;
  logic           clr_done;

  assign rd_addr = {ra[1], ra[0]};

  always #5 clk = ~clk;

  reg_file_param #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .N_RD  (NR)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done)
  );

  int checks = 0;
  int errors = 0;

  // Model: contents, remaining sweep cycles, expected outputs.
  logic [DW-1:0] mem [DEPTH];
  int            sweep_left = 0;
  logic [DW-1:0] exp_rd [NR];
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    sweep_left = 0;
    for (int k = 0; k < NR; k++) exp_rd[k] = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endfunction

  // Contents are invisible during a sweep (reads are zero) and all zero
  // once it ends, so the model clears everything when the sweep starts.
  function automatic void model_step();
    logic wr_ok;
    exp_done = 1'b0;
    if (sweep_left > 0) begin
      for (int k = 0; k < NR; k++) exp_rd[k] = '0;
      sweep_left--;
      if (sweep_left == 0) exp_done = 1'b1;
    end else begin
      wr_ok = we && !clr_req && (wr_addr != '0);
      for (int k = 0; k < NR; k++) begin
        exp_rd[k] = (ra[k] == '0) ? '0 : mem[ra[k]];
        if (BYP && wr_ok && (wr_addr == ra[k])) exp_rd[k] = wr_data;
      end
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        sweep_left = DEPTH;
      end else if (wr_ok) begin
        mem[wr_addr] = wr_data;
      end
    end
    exp_busy = (sweep_left > 0);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rd0"}, 64'(rd_data[DW-1:0]), 64'(exp_rd[0]));
    check({tag, ".rd1"}, 64'(rd_data[2*DW-1:DW]), 64'(exp_rd[1]));
    check({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check({tag, ".done"}, 64'(clr_done), 64'(exp_done));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    we = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    ra[0] = '0;
    ra[1] = '0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // Read 0 and 31 after reset
    ra[0] = 5'd0;
    ra[1] = 5'd31;
    cycle("rst_read");

    // Write / read back, r0 discard
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cycle("wr5");
    we = 1'b0; ra[0] = 5'd5; ra[1] = 5'd5;
    cycle("rd5");
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    cycle("wr0");
    we = 1'b0; ra[0] = 5'd0; ra[1] = 5'd0;
    cycle("rd0");

    // Write and read the same address on the same edge
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    ra[0] = 5'd7; ra[1] = 5'd5;
    cycle("byp7");
    we = 1'b0;
    cycle("after7");

    // Fill 1..31, sweep with writes attempted while busy
    for (int a = 1; a < DEPTH; a++) begin
      we = 1'b1; wr_addr = AW'(a); wr_data = $urandom() | 32'h1;
      ra[0] = AW'(a - 1); ra[1] = AW'(a);
      cycle("fill");
    end
    we = 1'b0;
    clr_req = 1'b1;
    cycle("sweep_go");
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wr_addr = AW'($urandom_range(1, 31));
      wr_data = $urandom() | 32'h1;
      clr_req = ($urandom_range(0, 3) == 0);
      ra[0] = AW'($urandom); ra[1] = AW'($urandom);
      cycle("sweeping");
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
      cycle("post_sweep");
    end

    // Write in the clr_req cycle is dropped
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    clr_req = 1'b1;
    cycle("clr_and_wr");
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) cycle("sweep2");
    ra[0] = 5'd3; ra[1] = 5'd3;
    cycle("rd3");

    // Reset in the middle of a sweep
    for (int a = 1; a < DEPTH; a++) begin
      we = 1'b1; wr_addr = AW'(a); wr_data = $urandom() | 32'h1;
      cycle("refill");
    end
    we = 1'b0;
    clr_req = 1'b1;
    cycle("sweep3_go");
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) cycle("sweep3");
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("abort");
    @(posedge clk);
    #1;
    check_all("abort_hold");
    clr_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ra[0] = AW'(a); ra[1] = AW'(a);
      cycle("post_abort");
    end
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    cycle("wr9");
    we = 1'b0; ra[0] = 5'd9; ra[1] = 5'd9;
    cycle("rd9");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      we = $urandom_range(0, 1);
      wr_addr = AW'($urandom);
      wr_data = $urandom();
      clr_req = ($urandom_range(0, 59) == 0);
      ra[0] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      ra[1] = AW'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
